// File: rtl/alu_seq.sv
// Handshaked, parametrised ALU: single-cycle arithmetic/branch ops, iterative
// one-bit-per-cycle shifter and a shift-add multiplier.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       inst_i,
    input  logic [WIDTH-1:0] reg1_i,
    input  logic [WIDTH-1:0] reg2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] reg_o,
    output logic [WIDTH-1:0] over_o,
    output logic             branch_o,
    output logic             over_flag_o
);
    localparam int CNTW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_SFL = 4'b0010,
                           OP_SFR = 4'b0011, OP_INC = 4'b0100, OP_DEC = 4'b0101,
                           OP_BNE = 4'b0110, OP_BEQ = 4'b0111, OP_BLT = 4'b1000,
                           OP_LHB = 4'b1001, OP_JMP = 4'b1010, OP_BLS = 4'b1011,
                           OP_MUL = 4'b1100;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic             br;
        logic             fl;
    } res_t;

    // Result of every op that completes on the accept edge; shifts only reach
    // here with a zero or out-of-range amount.
    function automatic res_t single_op(input logic [3:0] op,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
        res_t       r;
        logic [WIDTH:0] sum;
        r   = '0;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD: begin
                r.lo = sum[WIDTH-1:0];
                r.hi = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
                r.fl = sum[WIDTH];
            end
            OP_SUB:         r.lo = a - b;
            OP_SFL, OP_SFR: r.lo = (b == '0) ? a : '0;
            OP_INC:         r.lo = a + WIDTH'(1);
            OP_DEC:         r.lo = a - WIDTH'(1);
            OP_BNE:         r.br = (a != b);
            OP_BEQ:         r.br = (a == b);
            OP_BLT:         r.br = (a < b);
            OP_BLS:         r.br = ($signed(a) < $signed(b));
            OP_LHB:         r.lo = a & {{(WIDTH/2){1'b1}}, {(WIDTH/2){1'b0}}};
            OP_JMP:         r.br = 1'b1;
            default:        r = '0;
        endcase
        return r;
    endfunction

    state_t             r_state;
    logic [3:0]         r_op;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNTW-1:0]    r_cnt;
    logic               r_ready, r_valid, r_branch, r_flag;
    logic [WIDTH-1:0]   r_reg, r_over;

    logic               w_is_shift, w_multi;
    logic [2*WIDTH-1:0] w_sh_next, w_acc_next;
    res_t               w_single;

    assign w_is_shift = (inst_i == OP_SFL) || (inst_i == OP_SFR);
    assign w_multi    = (inst_i == OP_MUL) ||
                        (w_is_shift && (reg2_i != '0) && (reg2_i < WIDTH'(WIDTH)));
    assign w_single   = single_op(inst_i, reg1_i, reg2_i);
    // The shift register doubles as the multiplicand, advanced one bit per EXEC edge.
    assign w_sh_next  = (r_op == OP_SFR) ? (r_mcand >> 1) : (r_mcand << 1);
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_reg    <= '0;
            r_over   <= '0;
            r_branch <= 1'b0;
            r_flag   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_op    <= inst_i;
                        r_ready <= 1'b0;
                        if (w_multi) begin
                            r_state  <= EXEC;
                            r_mcand  <= {{WIDTH{1'b0}}, reg1_i};
                            r_mplier <= reg2_i;
                            r_acc    <= '0;
                            r_cnt    <= (inst_i == OP_MUL) ? CNTW'(WIDTH) : reg2_i[CNTW-1:0];
                        end else begin
                            r_state  <= DONE;
                            r_valid  <= 1'b1;
                            r_reg    <= w_single.lo;
                            r_over   <= w_single.hi;
                            r_branch <= w_single.br;
                            r_flag   <= w_single.fl;
                        end
                    end
                end
                EXEC: begin
                    r_mcand  <= w_sh_next;
                    r_mplier <= r_mplier >> 1;
                    r_acc    <= w_acc_next;
                    r_cnt    <= r_cnt - CNTW'(1);
                    if (r_cnt == CNTW'(1)) begin
                        r_state  <= DONE;
                        r_valid  <= 1'b1;
                        r_branch <= 1'b0;
                        if (r_op == OP_MUL) begin
                            r_reg  <= w_acc_next[WIDTH-1:0];
                            r_over <= w_acc_next[2*WIDTH-1:WIDTH];
                            r_flag <= |w_acc_next[2*WIDTH-1:WIDTH];
                        end else begin
                            r_reg  <= w_sh_next[WIDTH-1:0];
                            r_over <= '0;
                            r_flag <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o     = r_ready;
    assign valid_o     = r_valid;
    assign reg_o       = r_reg;
    assign over_o      = r_over;
    assign branch_o    = r_branch;
    assign over_flag_o = r_flag;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (WIDTH=8) against an arithmetic model.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b0;
    logic [3:0]   inst_i = '0;
    logic [W-1:0] reg1_i = '0;
    logic [W-1:0] reg2_i = '0;
    logic         ready_o, valid_o, branch_o, over_flag_o;
    logic [W-1:0] reg_o, over_o;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .inst_i(inst_i), .reg1_i(reg1_i), .reg2_i(reg2_i), .valid_o(valid_o),
        .ready_i(ready_i), .reg_o(reg_o), .over_o(over_o), .branch_o(branch_o),
        .over_flag_o(over_flag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode definitions.
    function automatic void model(input int op, input int a, input int b,
                                  output int lo, output int hi, output int br,
                                  output int fl, output int lat);
        int sa, sb, p;
        lo = 0; hi = 0; br = 0; fl = 0; lat = 1;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0:  begin lo = (a + b) % 256; hi = (a + b) / 256; fl = hi; end
            1:  lo = (a - b + 256) % 256;
            2:  begin lo = (b >= W) ? 0 : (a * (1 << b)) % 256; lat = (b >= 1 && b < W) ? b + 1 : 1; end
            3:  begin lo = (b >= W) ? 0 : a / (1 << b); lat = (b >= 1 && b < W) ? b + 1 : 1; end
            4:  lo = (a + 1) % 256;
            5:  lo = (a + 255) % 256;
            6:  br = (a != b) ? 1 : 0;
            7:  br = (a == b) ? 1 : 0;
            8:  br = (a < b) ? 1 : 0;
            9:  lo = a - (a % 16);
            10: br = 1;
            11: br = (sa < sb) ? 1 : 0;
            12: begin p = a * b; lo = p % 256; hi = p / 256; fl = (hi != 0) ? 1 : 0; lat = W + 1; end
            default: ;
        endcase
    endfunction

    task automatic do_op(input int op, input int a, input int b, input int bp, input bit scramble);
        int lo, hi, br, fl, lat, got_lat, guard;
        int h_reg, h_over, h_br, h_fl;
        model(op, a, b, lo, hi, br, fl, lat);
        guard = 0;
        while (!ready_o && guard < 50) begin
            @(posedge clk_i); #1; guard++;
        end
        check("ready_idle", int'(ready_o), 1);
        inst_i = 4'(op); reg1_i = 8'(a); reg2_i = 8'(b); valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        got_lat = 1;
        while (!valid_o && got_lat < 40) begin
            if (scramble) begin
                reg1_i = 8'($urandom); reg2_i = 8'($urandom);
                inst_i = 4'($urandom); valid_i = 1'($urandom);
            end
            @(posedge clk_i); #1; got_lat++;
        end
        valid_i = 1'b0;
        check($sformatf("lat op%0d", op), got_lat, lat);
        check($sformatf("reg op%0d a=%0h b=%0h", op, a, b), int'(reg_o), lo);
        check($sformatf("over op%0d", op), int'(over_o), hi);
        check($sformatf("branch op%0d", op), int'(branch_o), br);
        check($sformatf("flag op%0d", op), int'(over_flag_o), fl);
        check("ready_done", int'(ready_o), 0);
        h_reg = int'(reg_o); h_over = int'(over_o); h_br = int'(branch_o); h_fl = int'(over_flag_o);
        for (int i = 0; i < bp; i++) begin
            valid_i = 1'($urandom); inst_i = 4'($urandom);
            reg1_i = 8'($urandom); reg2_i = 8'($urandom);
            @(posedge clk_i); #1;
            check("hold_valid", int'(valid_o), 1);
            check("hold_ready", int'(ready_o), 0);
            check("hold_out", {int'(reg_o) * 256 + int'(over_o)} * 4 + int'(branch_o) * 2 + int'(over_flag_o),
                  (h_reg * 256 + h_over) * 4 + h_br * 2 + h_fl);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        check("release_valid", int'(valid_o), 0);
        check("release_ready", int'(ready_o), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int op, b;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", int'(ready_o), 1);
        check("rst_valid", int'(valid_o), 0);
        check("rst_outs", int'(reg_o) + int'(over_o) + int'(branch_o) + int'(over_flag_o), 0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_ready", int'(ready_o), 1);
        check("post_rst_valid", int'(valid_o), 0);

        // Directed cases
        do_op(0, 8'hF0, 8'h20, 0, 1'b0);
        do_op(0, 8'h01, 8'h02, 0, 1'b0);
        do_op(2, 8'h81, 3, 0, 1'b1);
        do_op(3, 8'h80, 7, 0, 1'b1);
        do_op(2, 8'h81, 0, 0, 1'b0);
        do_op(3, 8'h81, 9, 0, 1'b0);
        do_op(12, 8'hFF, 8'hFF, 0, 1'b1);
        do_op(12, 8'h0F, 8'h03, 0, 1'b1);
        do_op(12, 8'h5A, 8'h00, 0, 1'b0);
        do_op(8, 8'h80, 8'h01, 0, 1'b0);
        do_op(11, 8'h80, 8'h01, 0, 1'b0);
        do_op(7, 5, 5, 0, 1'b0);
        do_op(6, 5, 5, 0, 1'b0);
        do_op(10, 0, 0, 0, 1'b0);
        do_op(9, 8'hAB, 0, 0, 1'b0);
        do_op(15, 8'hFF, 8'hFF, 0, 1'b0);
        do_op(1, 8'h03, 8'h05, 5, 1'b0);
        do_op(5, 8'h00, 8'h00, 0, 1'b0);
        do_op(4, 8'hFF, 8'h00, 0, 1'b0);

        // Reset during MUL iteration must abort with no result.
        inst_i = 4'd12; reg1_i = 8'hFF; reg2_i = 8'hFF; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        check("abort_ready", int'(ready_o), 1);
        check("abort_valid", int'(valid_o), 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            if (valid_o) seen = 1'b1;
        end
        check("abort_no_result", int'(seen), 0);

        // Randomised ops
        for (int k = 0; k < 80; k++) begin
            op = int'($urandom_range(0, 15));
            b  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
            do_op(op, int'($urandom_range(0, 255)), b, int'($urandom_range(0, 3)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
